// File: rtl/sonar_rx_frame.sv
// Serial receiver (7 data bits, even parity, 2 stop bits) and "AAA,DDD#" parser.
// Decoded angle and distance are presented as BCD with a one-cycle frame_pronto pulse.
module sonar_rx_frame #(
  parameter int TICKS_POR_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        frame_pronto,
  output logic        erro_paridade,
  output logic        erro_formato,
  output logic [3:0]  db_estado
);

  localparam int CW = $clog2(TICKS_POR_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(TICKS_POR_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(TICKS_POR_BIT / 2 - 1);

  typedef enum logic [2:0] {
    OCIOSO, START, DADOS, PARIDADE, STOP1, STOP2
  } rx_state_t;

  logic sync1_q, sync2_q, prev_q;
  logic rx_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Edge (not level) detect: a low stop bit cannot re-arm the receiver.
  assign rx_fall = prev_q & ~sync2_q;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    data_q, data_d;
  logic          perr_q, perr_d;
  logic          serr_q, serr_d;
  logic          byte_vld, byte_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= OCIOSO;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    data_d   = data_q;
    perr_d   = perr_q;
    serr_d   = serr_q;
    byte_vld = 1'b0;
    byte_err = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        cnt_d = '0;
        if (rx_fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? OCIOSO : DADOS;
        end
      end
      DADOS: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          data_d = {sync2_q, data_q[6:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd6) state_d = PARIDADE;
        end
      end
      PARIDADE: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = (^data_q) ^ sync2_q;
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          serr_d  = ~sync2_q;
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          byte_vld = 1'b1;
          byte_err = perr_q | serr_q | ~sync2_q;
          state_d  = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  logic [2:0]  pos_q, pos_d;
  logic        resync_q, resync_d;
  logic [11:0] ang_sh_q, ang_sh_d;
  logic [11:0] dst_sh_q, dst_sh_d;
  logic [11:0] ang_q, ang_d;
  logic [11:0] dst_q, dst_d;
  logic        frm_q, frm_d;
  logic        epar_q, epar_d;
  logic        efmt_q, efmt_d;
  logic        is_digit, is_comma, is_hash;
  logic        char_ok;

  assign is_digit = (data_q[6:4] == 3'b011) && (data_q[3:0] <= 4'd9);
  assign is_comma = (data_q == 7'h2C);
  assign is_hash  = (data_q == 7'h23);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q    <= '0;
      resync_q <= 1'b0;
      ang_sh_q <= '0;
      dst_sh_q <= '0;
      ang_q    <= '0;
      dst_q    <= '0;
      frm_q    <= 1'b0;
      epar_q   <= 1'b0;
      efmt_q   <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      resync_q <= resync_d;
      ang_sh_q <= ang_sh_d;
      dst_sh_q <= dst_sh_d;
      ang_q    <= ang_d;
      dst_q    <= dst_d;
      frm_q    <= frm_d;
      epar_q   <= epar_d;
      efmt_q   <= efmt_d;
    end
  end

  always_comb begin
    pos_d    = pos_q;
    resync_d = resync_q;
    ang_sh_d = ang_sh_q;
    dst_sh_d = dst_sh_q;
    ang_d    = ang_q;
    dst_d    = dst_q;
    frm_d    = 1'b0;
    epar_d   = 1'b0;
    efmt_d   = 1'b0;
    char_ok  = 1'b0;
    if (byte_vld) begin
      if (byte_err) begin
        epar_d   = 1'b1;
        resync_d = 1'b1;
      end else if (resync_q) begin
        if (is_hash) begin
          resync_d = 1'b0;
          pos_d    = '0;
        end
      end else begin
        unique case (pos_q)
          3'd0, 3'd1, 3'd2: begin
            char_ok  = is_digit;
            ang_sh_d = is_digit ? {ang_sh_q[7:0], data_q[3:0]} : ang_sh_q;
          end
          3'd3: char_ok = is_comma;
          3'd4, 3'd5, 3'd6: begin
            char_ok  = is_digit;
            dst_sh_d = is_digit ? {dst_sh_q[7:0], data_q[3:0]} : dst_sh_q;
          end
          default: char_ok = is_hash;
        endcase
        if (!char_ok) begin
          efmt_d   = 1'b1;
          resync_d = 1'b1;
        end else if (pos_q == 3'd7) begin
          ang_d = ang_sh_q;
          dst_d = dst_sh_q;
          frm_d = 1'b1;
          pos_d = '0;
        end else begin
          pos_d = pos_q + 3'd1;
        end
      end
    end
  end

  assign angulo        = ang_q;
  assign distancia     = dst_q;
  assign frame_pronto  = frm_q;
  assign erro_paridade = epar_q;
  assign erro_formato  = efmt_q;
  assign db_estado     = resync_q ? 4'd8 : {1'b0, pos_q};

endmodule

// File: tb/tb_sonar_rx_frame.sv
// Directed bench for sonar_rx_frame: serial stimulus at 4 clocks per bit,
// pulse counters sampled on the falling clock edge.
module tb_sonar_rx_frame;

  localparam int T = 4;

  logic        clock;
  logic        reset;
  logic        rx_serial;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        frame_pronto;
  logic        erro_paridade;
  logic        erro_formato;
  logic [3:0]  db_estado;

  int tests_run;
  int tests_failed;
  int n_frm, n_par, n_fmt, n_long;
  logic frm_prev;

  sonar_rx_frame #(.TICKS_POR_BIT(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .angulo       (angulo),
    .distancia    (distancia),
    .frame_pronto (frame_pronto),
    .erro_paridade(erro_paridade),
    .erro_formato (erro_formato),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    n_frm = 0; n_par = 0; n_fmt = 0; n_long = 0; frm_prev = 1'b0;
  end

  always @(negedge clock) begin
    if (frame_pronto) n_frm = n_frm + 1;
    if (erro_paridade) n_par = n_par + 1;
    if (erro_formato) n_fmt = n_fmt + 1;
    if (frame_pronto && frm_prev) n_long = n_long + 1;
    frm_prev = frame_pronto;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic wait_bits(input int n);
    repeat (n * T) @(negedge clock);
  endtask

  task automatic send_char(input logic [6:0] c, input bit flip);
    rx_serial = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 7; i++) begin
      rx_serial = c[i];
      wait_bits(1);
    end
    rx_serial = (^c) ^ flip;
    wait_bits(1);
    rx_serial = 1'b1;
    wait_bits(2);
  endtask

  task automatic send_str(input string s, input int bad_idx);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i][6:0], i == bad_idx);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    rx_serial = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    settle();
    tests_run++;
    if (angulo !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_ang: got %h want 000", angulo);
    end
    tests_run++;
    if (distancia !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_dist: got %h want 000", distancia);
    end
    tests_run++;
    if (db_estado !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_db: got %0d want 0", db_estado);
    end
    tests_run++;
    if ({frame_pronto, erro_paridade, erro_formato} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_pulses: got %b want 000",
               {frame_pronto, erro_paridade, erro_formato});
    end
  endtask

  task automatic test_basic();
    int f0, p0, e0;
    f0 = n_frm; p0 = n_par; e0 = n_fmt;
    send_str("045", -1);
    settle();
    tests_run++;
    if (db_estado !== 4'd3) begin
      tests_failed++;
      $display("FAIL basic_pos3: got %0d want 3", db_estado);
    end
    tests_run++;
    if (angulo !== 12'h000) begin
      tests_failed++;
      $display("FAIL basic_shadow_hidden: got %h want 000", angulo);
    end
    send_str(",123#", -1);
    settle();
    tests_run++;
    if (n_frm - f0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_frames: got %0d want 1", n_frm - f0);
    end
    tests_run++;
    if (angulo !== 12'h045 || distancia !== 12'h123) begin
      tests_failed++;
      $display("FAIL basic_out: got %h/%h want 045/123", angulo, distancia);
    end
    tests_run++;
    if (n_par - p0 + n_fmt - e0 !== 0) begin
      tests_failed++;
      $display("FAIL basic_errs: got %0d want 0", n_par - p0 + n_fmt - e0);
    end
    tests_run++;
    if (db_estado !== 4'd0) begin
      tests_failed++;
      $display("FAIL basic_pos0: got %0d want 0", db_estado);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = n_frm;
    send_str("090,007#", -1);
    repeat (2) @(negedge clock);
    tests_run++;
    if (angulo !== 12'h090 || distancia !== 12'h007) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h/%h want 090/007", angulo, distancia);
    end
    send_str("180,250#", -1);
    settle();
    tests_run++;
    if (n_frm - f0 !== 2) begin
      tests_failed++;
      $display("FAIL b2b_frames: got %0d want 2", n_frm - f0);
    end
    tests_run++;
    if (angulo !== 12'h180 || distancia !== 12'h250) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h/%h want 180/250", angulo, distancia);
    end
  endtask

  task automatic test_format();
    int f0, e0, p0;
    f0 = n_frm; e0 = n_fmt; p0 = n_par;
    send_str("01X", -1);
    settle();
    tests_run++;
    if (n_fmt - e0 !== 1) begin
      tests_failed++;
      $display("FAIL fmt_pulse: got %0d want 1", n_fmt - e0);
    end
    tests_run++;
    if (db_estado !== 4'd8) begin
      tests_failed++;
      $display("FAIL fmt_resync: got %0d want 8", db_estado);
    end
    send_str(",1", -1);
    send_str("030,040#", -1);
    settle();
    tests_run++;
    if (n_frm - f0 !== 0) begin
      tests_failed++;
      $display("FAIL fmt_absorbed: got %0d want 0", n_frm - f0);
    end
    tests_run++;
    if (angulo !== 12'h180 || db_estado !== 4'd0) begin
      tests_failed++;
      $display("FAIL fmt_hold: got %h db %0d want 180 db 0", angulo, db_estado);
    end
    send_str("031,041#", -1);
    settle();
    tests_run++;
    if (n_frm - f0 !== 1 || angulo !== 12'h031 || distancia !== 12'h041) begin
      tests_failed++;
      $display("FAIL fmt_recover: got %0d %h/%h want 1 031/041",
               n_frm - f0, angulo, distancia);
    end
    tests_run++;
    if (n_fmt - e0 !== 1 || n_par - p0 !== 0) begin
      tests_failed++;
      $display("FAIL fmt_err_count: got %0d/%0d want 1/0",
               n_fmt - e0, n_par - p0);
    end
  endtask

  task automatic test_parity();
    int f0, e0, p0;
    f0 = n_frm; e0 = n_fmt; p0 = n_par;
    send_str("077,088#", 4);
    settle();
    tests_run++;
    if (n_par - p0 !== 1 || n_fmt - e0 !== 0) begin
      tests_failed++;
      $display("FAIL par_pulses: got par %0d fmt %0d want 1 0",
               n_par - p0, n_fmt - e0);
    end
    tests_run++;
    if (n_frm - f0 !== 0) begin
      tests_failed++;
      $display("FAIL par_frames: got %0d want 0", n_frm - f0);
    end
    tests_run++;
    if (angulo !== 12'h031 || distancia !== 12'h041) begin
      tests_failed++;
      $display("FAIL par_hold: got %h/%h want 031/041", angulo, distancia);
    end
  endtask

  task automatic test_glitch();
    int f0, e0, p0;
    send_str("12", -1);
    settle();
    f0 = n_frm; e0 = n_fmt; p0 = n_par;
    rx_serial = 1'b0;
    @(negedge clock);
    rx_serial = 1'b1;
    wait_bits(12);
    tests_run++;
    if (n_frm - f0 + n_fmt - e0 + n_par - p0 !== 0) begin
      tests_failed++;
      $display("FAIL glitch_pulses: got %0d want 0",
               n_frm - f0 + n_fmt - e0 + n_par - p0);
    end
    tests_run++;
    if (db_estado !== 4'd2) begin
      tests_failed++;
      $display("FAIL glitch_db: got %0d want 2", db_estado);
    end
    send_str("3,456#", -1);
    settle();
    tests_run++;
    if (angulo !== 12'h123 || distancia !== 12'h456) begin
      tests_failed++;
      $display("FAIL glitch_frame: got %h/%h want 123/456", angulo, distancia);
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    send_str("987,6", -1);
    rx_serial = 1'b0;
    wait_bits(1);
    rx_serial = 1'b1;
    wait_bits(2);
    reset = 1'b1;
    #1;
    tests_run++;
    if (angulo !== 12'h000 || distancia !== 12'h000 || db_estado !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_mid: got %h/%h db %0d want 000/000 db 0",
               angulo, distancia, db_estado);
    end
    rx_serial = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    settle();
    f0 = n_frm;
    send_str("002,999#", -1);
    settle();
    tests_run++;
    if (n_frm - f0 !== 1 || angulo !== 12'h002 || distancia !== 12'h999) begin
      tests_failed++;
      $display("FAIL rst_after: got %0d %h/%h want 1 002/999",
               n_frm - f0, angulo, distancia);
    end
    tests_run++;
    if (n_long !== 0) begin
      tests_failed++;
      $display("FAIL pulse_width: got %0d long pulses want 0", n_long);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    rx_serial = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_format();
    test_parity();
    test_glitch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
